// File: rtl/axilite_csr_pkg.sv
// Definitions shared by the AXI4-Lite CSR slave stages (AW, W, B):
// response codes and default bus geometry.
package axilite_csr_pkg;

    localparam int AXI_ADDR_SIZE  = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_DATA_SIZE  = 128;
    localparam int AW_FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } axi_resp_e;

    // Pointer width for a power-of-two FIFO; a single-entry FIFO still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axilite_csr_addr_fifo.sv
// Generic synchronous FIFO with power-of-two depth. The output is the entry at
// the read pointer; pushes when full and pops when empty are dropped.
module axilite_csr_addr_fifo
    import axilite_csr_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int PW    = ptr_width(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no branch can leave one unassigned and infer a latch.
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: storage is cleared on reset (not just the pointers) so the head reads 0 until the first push.
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, whatever the statement order.
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/axilite_csr_write_addr.sv
// AXI4-Lite AW channel front end: buffers accepted write addresses and presents
// the oldest one to the write-data stage until that stage pops it.
module axilite_csr_write_addr
    import axilite_csr_pkg::*;
#(
    parameter  int ADDR_SIZE  = AXI_ADDR_SIZE,
    parameter  int DATA_SIZE  = AXI_DATA_SIZE,
    parameter  int DATA_WIDTH = AXI_DATA_WIDTH,
    parameter  int DEPTH      = AW_FIFO_DEPTH,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE-1:0] awaddr,
    input  logic [2:0]           awprot,
    input  logic                 awvalid,
    output logic                 awready,
    output logic [ADDR_SIZE-1:0] addr,
    output logic                 addr_good,
    input  logic                 deassert_addr,
    output logic [CW-1:0]        aw_count
);

    logic          awready_q, awready_d;
    logic          push;
    logic          pop;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;
    logic          unused_full;
    logic          unused_awprot;
    logic [31:0]   unused_params;

    // Protection bits and data geometry are handled by later stages.
    assign unused_awprot = ^awprot;
    assign unused_params = 32'(DATA_SIZE ^ DATA_WIDTH);

    assign push = awvalid && awready_q;
    assign pop  = deassert_addr && !empty;

    axilite_csr_addr_fifo #(
        .WIDTH (ADDR_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (awaddr),
        .dout  (addr),
        .count (count),
        .full  (unused_full),
        .empty (empty)
    );

    // awready looks one edge ahead at the occupancy, so a pop while full frees
    // a slot only from the following cycle on.
    always_comb begin
        next_count = count;
        if (push && !pop) begin
            next_count = count + 1'b1;
        end else if (pop && !push) begin
            next_count = count - 1'b1;
        end
        awready_d = (next_count < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awready_q <= 1'b0;
        end else begin
            awready_q <= awready_d;
        end
    end

    assign awready   = awready_q;
    assign addr_good = !empty;
    assign aw_count  = count;

endmodule

// File: tb/tb_axilite_csr_write_addr.sv
// Bench for axilite_csr_write_addr: directed scenarios with fixed expectations,
// then randomized traffic checked against a queue-based reference model.
module tb_axilite_csr_write_addr;
    import axilite_csr_pkg::*;

    localparam int ADDR_SIZE = 32;
    localparam int DEPTH     = 2;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [ADDR_SIZE-1:0] awaddr;
    logic [2:0]           awprot;
    logic                 awvalid;
    logic                 awready;
    logic [ADDR_SIZE-1:0] addr;
    logic                 addr_good;
    logic                 deassert_addr;
    logic [CW-1:0]        aw_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of buffered addresses plus the expected awready.
    logic [ADDR_SIZE-1:0] model_q [$];
    bit                   model_awready   = 1'b0;
    bit                   model_zero_head = 1'b1;

    always #5 clk = ~clk;

    axilite_csr_write_addr #(
        .ADDR_SIZE  (ADDR_SIZE),
        .DATA_SIZE  (128),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .awaddr        (awaddr),
        .awprot        (awprot),
        .awvalid       (awvalid),
        .awready       (awready),
        .addr          (addr),
        .addr_good     (addr_good),
        .deassert_addr (deassert_addr),
        .aw_count      (aw_count)
    );

    // One clock edge: the model applies the rules to the inputs seen at the
    // edge, then outputs are sampled 1 time unit later.
    task automatic tick();
        bit accept;
        bit popped;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_awready   = 1'b0;
            model_zero_head = 1'b1;
        end else begin
            accept = awvalid && model_awready;
            popped = deassert_addr && (model_q.size() != 0);
            if (popped) void'(model_q.pop_front());
            if (accept) begin
                model_q.push_back(awaddr);
                model_zero_head = 1'b0;
            end
            model_awready = (model_q.size() < DEPTH);
        end
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        awvalid = 1'b1;
        awaddr  = 32'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (awready !== 1'b0) begin n_fail++; $display("FAIL reset_awready cyc%0d: got %0b want 0", i, awready); end
            n_checks++;
            if (addr_good !== 1'b0) begin n_fail++; $display("FAIL reset_addr_good cyc%0d: got %0b want 0", i, addr_good); end
            n_checks++;
            if (aw_count !== CW'(0)) begin n_fail++; $display("FAIL reset_count cyc%0d: got %0d want 0", i, aw_count); end
            n_checks++;
            if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr cyc%0d: got %h want 0", i, addr); end
        end
        rst     = 1'b0;
        awvalid = 1'b0;
        tick();
        n_checks++;
        if (awready !== 1'b1) begin n_fail++; $display("FAIL reset_release_awready: got %0b want 1", awready); end
        n_checks++;
        if (addr_good !== 1'b0) begin n_fail++; $display("FAIL reset_release_good: got %0b want 0", addr_good); end
    endtask

    task automatic test_single_write();
        awaddr  = 32'h8;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        n_checks++;
        if (addr !== 32'h8 || addr_good !== 1'b1) begin n_fail++; $display("FAIL single_head: got %h/%0b want 8/1", addr, addr_good); end
        n_checks++;
        if (aw_count !== CW'(1)) begin n_fail++; $display("FAIL single_count1: got %0d want 1", aw_count); end
        tick();
        n_checks++;
        if (addr !== 32'h8 || addr_good !== 1'b1) begin n_fail++; $display("FAIL single_hold: got %h/%0b want 8/1", addr, addr_good); end
        deassert_addr = 1'b1;
        tick();
        deassert_addr = 1'b0;
        n_checks++;
        if (addr_good !== 1'b0) begin n_fail++; $display("FAIL single_pop_good: got %0b want 0", addr_good); end
        n_checks++;
        if (aw_count !== CW'(0)) begin n_fail++; $display("FAIL single_count0: got %0d want 0", aw_count); end
    endtask

    task automatic test_fill_backpressure();
        awvalid = 1'b1;
        awaddr  = 32'h0;
        tick();
        awaddr = 32'h4;
        tick();
        n_checks++;
        if (aw_count !== CW'(2) || awready !== 1'b0) begin n_fail++; $display("FAIL fill_full: count %0d awready %0b want 2/0", aw_count, awready); end
        awaddr = 32'h8;
        tick();
        n_checks++;
        if (aw_count !== CW'(2) || awready !== 1'b0 || addr !== 32'h0) begin
            n_fail++; $display("FAIL fill_blocked: count %0d awready %0b addr %h want 2/0/0", aw_count, awready, addr);
        end
        deassert_addr = 1'b1;
        tick();
        deassert_addr = 1'b0;
        n_checks++;
        if (aw_count !== CW'(1) || awready !== 1'b1 || addr !== 32'h4) begin
            n_fail++; $display("FAIL fill_pop_no_push: count %0d awready %0b addr %h want 1/1/4", aw_count, awready, addr);
        end
        tick();
        awvalid = 1'b0;
        n_checks++;
        if (aw_count !== CW'(2) || awready !== 1'b0 || addr !== 32'h4) begin
            n_fail++; $display("FAIL fill_late_accept: count %0d awready %0b addr %h want 2/0/4", aw_count, awready, addr);
        end
        deassert_addr = 1'b1;
        tick();
        n_checks++;
        if (addr !== 32'h8 || addr_good !== 1'b1) begin n_fail++; $display("FAIL fill_order_third: got %h/%0b want 8/1", addr, addr_good); end
        tick();
        deassert_addr = 1'b0;
        n_checks++;
        if (addr_good !== 1'b0 || aw_count !== CW'(0)) begin n_fail++; $display("FAIL fill_drained: good %0b count %0d want 0/0", addr_good, aw_count); end
    endtask

    task automatic test_simul_push_pop();
        awvalid = 1'b1;
        awaddr  = 32'hC;
        tick();
        awaddr        = 32'h4;
        deassert_addr = 1'b1;
        tick();
        awvalid       = 1'b0;
        deassert_addr = 1'b0;
        n_checks++;
        if (addr !== 32'h4 || addr_good !== 1'b1 || aw_count !== CW'(1)) begin
            n_fail++; $display("FAIL simul_push_pop: addr %h good %0b count %0d want 4/1/1", addr, addr_good, aw_count);
        end
        deassert_addr = 1'b1;
        tick();
        deassert_addr = 1'b0;
    endtask

    task automatic test_spurious_pop();
        deassert_addr = 1'b1;
        tick();
        tick();
        deassert_addr = 1'b0;
        n_checks++;
        if (aw_count !== CW'(0) || addr_good !== 1'b0) begin
            n_fail++; $display("FAIL spurious_underflow: count %0d good %0b want 0/0", aw_count, addr_good);
        end
        awaddr  = 32'h0;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        n_checks++;
        if (addr !== 32'h0 || addr_good !== 1'b1 || aw_count !== CW'(1)) begin
            n_fail++; $display("FAIL spurious_then_push: addr %h good %0b count %0d want 0/1/1", addr, addr_good, aw_count);
        end
        deassert_addr = 1'b1;
        tick();
        deassert_addr = 1'b0;
    endtask

    task automatic test_reset_mid();
        awvalid = 1'b1;
        awaddr  = 32'hA0;
        tick();
        awaddr = 32'hB0;
        tick();
        n_checks++;
        if (aw_count !== CW'(2)) begin n_fail++; $display("FAIL midrst_fill: count %0d want 2", aw_count); end
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        awvalid = 1'b0;
        n_checks++;
        if (aw_count !== CW'(0) || addr_good !== 1'b0 || addr !== 32'h0 || awready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_cleared: count %0d good %0b addr %h awready %0b want 0/0/0/0", aw_count, addr_good, addr, awready);
        end
        tick();
        awaddr  = 32'hC;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        n_checks++;
        if (addr !== 32'hC || addr_good !== 1'b1 || aw_count !== CW'(1)) begin
            n_fail++; $display("FAIL midrst_next_head: addr %h good %0b count %0d want c/1/1", addr, addr_good, aw_count);
        end
        deassert_addr = 1'b1;
        tick();
        deassert_addr = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 63) == 0);
            awvalid       = ($urandom_range(0, 9) < 6);
            deassert_addr = ($urandom_range(0, 9) < 4);
            awaddr        = $urandom;
            awprot        = 3'($urandom_range(0, 7));
            tick();
            n_checks++;
            if (aw_count !== CW'(model_q.size())) begin n_fail++; $display("FAIL rand_count cyc%0d: got %0d want %0d", i, aw_count, model_q.size()); end
            n_checks++;
            if (awready !== model_awready) begin n_fail++; $display("FAIL rand_awready cyc%0d: got %0b want %0b", i, awready, model_awready); end
            n_checks++;
            if (addr_good !== (model_q.size() != 0)) begin n_fail++; $display("FAIL rand_good cyc%0d: got %0b want %0b", i, addr_good, model_q.size() != 0); end
            if (model_q.size() != 0) begin
                n_checks++;
                if (addr !== model_q[0]) begin n_fail++; $display("FAIL rand_head cyc%0d: got %h want %h", i, addr, model_q[0]); end
            end else if (model_zero_head) begin
                n_checks++;
                if (addr !== 32'h0) begin n_fail++; $display("FAIL rand_reset_head cyc%0d: got %h want 0", i, addr); end
            end
        end
        rst           = 1'b0;
        awvalid       = 1'b0;
        deassert_addr = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        awaddr        = '0;
        awprot        = 3'b000;
        awvalid       = 1'b0;
        deassert_addr = 1'b0;
        test_reset();
        test_single_write();
        test_fill_backpressure();
        test_simul_push_pop();
        test_spurious_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
